// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download byte-to-word packer.
// One FIFO entry carries a word address, the 16-bit data and its byte enables.
package rom_dl_pkg;

   typedef struct packed {
      logic [23:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } dl_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } dl_st_e;

   localparam logic [1:0] BE_HI  = 2'b10;
   localparam logic [1:0] BE_LO  = 2'b01;
   localparam logic [1:0] BE_ALL = 2'b11;

   function automatic dl_word_t make_word(input logic [23:0] addr,
                                          input logic [7:0]  hi,
                                          input logic [7:0]  lo,
                                          input logic [1:0]  be);
      dl_word_t w;
      w.addr = addr;
      w.data = {hi, lo};
      w.be   = be;
      return w;
   endfunction

endpackage

// File: rtl/rom_dl_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
// Pointers wrap modulo the depth; occupancy is one bit wider than the pointers.
module rom_dl_fifo #(
   parameter type T  = logic [7:0],
   parameter int  AW = 3
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        push,
   input  T            push_data,
   input  logic        pop,
   output T            head,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);

   localparam int DEPTH = 2 ** AW;

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          do_pop;

   assign do_pop = pop && !empty;

   // Storage is left unreset; the top gates the head fields while empty.
   always_ff @(posedge clk_sys) begin
      if (push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;
   assign full  = (count_reg == (AW + 1)'(DEPTH));
   assign empty = (count_reg == '0);

endmodule

// File: rtl/rom_dl_packer.sv
// Pairs download bytes into big-endian 16-bit words, buffers them in a FIFO
// and writes them to SDRAM one per handshake, signalling the end of the drain.
module rom_dl_packer
   import rom_dl_pkg::*;
#(
   parameter int FIFO_AW  = 3,
   parameter int WAIT_LVL = 6
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        sdram_req,
   input  logic        sdram_ack,
   output logic [23:0] sdram_addr,
   output logic [15:0] sdram_din,
   output logic [1:0]  sdram_be,
   output logic        dl_busy,
   output logic        dl_done
);

   dl_st_e           state_reg, state_next;
   logic             wr_d_reg, dl_d_reg;
   logic             rise_hold_reg, rise_hold_next;
   logic             stg_vld_reg;
   logic [24:0]      stg_addr_reg;
   logic [7:0]       stg_data_reg;
   logic             pend_vld_reg, pend_vld_next;
   logic [23:0]      pend_addr_reg, pend_addr_next;
   logic [7:0]       pend_data_reg, pend_data_next;
   logic             wait_reg, done_reg, done_next;
   logic             byte_evt, dl_rise, flush_pend, stg_done;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [FIFO_AW:0] fifo_count;
   dl_word_t         push_word, fifo_head;

   assign dl_rise  = ioctl_download && !dl_d_reg;
   assign byte_evt = ioctl_wr && !wr_d_reg && ioctl_download && (state_reg == RUN);

   // FLUSH waits for a byte still in the stage so that at most one push happens per cycle.
   always_comb begin
      state_next     = state_reg;
      rise_hold_next = rise_hold_reg;
      done_next      = 1'b0;
      flush_pend     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (dl_rise || rise_hold_reg) begin
               state_next     = RUN;
               rise_hold_next = 1'b0;
            end
         end
         RUN: begin
            if (!ioctl_download) begin
               state_next = FLUSH;
            end
         end
         FLUSH: begin
            if (dl_rise) begin
               rise_hold_next = 1'b1;
            end
            if (!stg_vld_reg) begin
               flush_pend = pend_vld_reg;
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (dl_rise) begin
               rise_hold_next = 1'b1;
            end
            if (fifo_empty) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A mismatch leaves the new byte in the stage for a second pass once pending is flushed.
   always_comb begin
      fifo_push      = 1'b0;
      push_word      = '0;
      stg_done       = 1'b0;
      pend_vld_next  = pend_vld_reg;
      pend_addr_next = pend_addr_reg;
      pend_data_next = pend_data_reg;
      if (stg_vld_reg) begin
         if (!stg_addr_reg[0] && !pend_vld_reg) begin
            pend_vld_next  = 1'b1;
            pend_addr_next = stg_addr_reg[24:1];
            pend_data_next = stg_data_reg;
            stg_done       = 1'b1;
         end else if (stg_addr_reg[0] && pend_vld_reg &&
                      (pend_addr_reg == stg_addr_reg[24:1])) begin
            fifo_push     = 1'b1;
            push_word     = make_word(pend_addr_reg, pend_data_reg, stg_data_reg, BE_ALL);
            pend_vld_next = 1'b0;
            stg_done      = 1'b1;
         end else if (pend_vld_reg) begin
            fifo_push     = 1'b1;
            push_word     = make_word(pend_addr_reg, pend_data_reg, 8'h00, BE_HI);
            pend_vld_next = 1'b0;
         end else begin
            fifo_push = 1'b1;
            push_word = make_word(stg_addr_reg[24:1], 8'h00, stg_data_reg, BE_LO);
            stg_done  = 1'b1;
         end
      end else if (flush_pend) begin
         fifo_push     = 1'b1;
         push_word     = make_word(pend_addr_reg, pend_data_reg, 8'h00, BE_HI);
         pend_vld_next = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         wr_d_reg      <= 1'b0;
         dl_d_reg      <= 1'b0;
         rise_hold_reg <= 1'b0;
         stg_vld_reg   <= 1'b0;
         stg_addr_reg  <= '0;
         stg_data_reg  <= '0;
         pend_vld_reg  <= 1'b0;
         pend_addr_reg <= '0;
         pend_data_reg <= '0;
         wait_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         wr_d_reg      <= ioctl_wr;
         dl_d_reg      <= ioctl_download;
         rise_hold_reg <= rise_hold_next;
         if (byte_evt) begin
            stg_vld_reg  <= 1'b1;
            stg_addr_reg <= ioctl_addr;
            stg_data_reg <= ioctl_dout;
         end else if (stg_done) begin
            stg_vld_reg <= 1'b0;
         end
         pend_vld_reg  <= pend_vld_next;
         pend_addr_reg <= pend_addr_next;
         pend_data_reg <= pend_data_next;
         wait_reg      <= (fifo_count >= (FIFO_AW + 1)'(WAIT_LVL));
         done_reg      <= done_next;
      end
   end

   assign fifo_pop = sdram_ack && !fifo_empty;

   rom_dl_fifo #(
      .T  (dl_word_t),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .push      (fifo_push && !fifo_full),
      .push_data (push_word),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Head fields are forced to zero while empty so stale RAM contents never show.
   assign sdram_req  = !fifo_empty;
   assign sdram_addr = fifo_empty ? '0 : fifo_head.addr;
   assign sdram_din  = fifo_empty ? '0 : fifo_head.data;
   assign sdram_be   = fifo_empty ? '0 : fifo_head.be;
   assign ioctl_wait = wait_reg;
   assign dl_busy    = (state_reg != IDLE);
   assign dl_done    = done_reg;

endmodule

// File: tb/tb_rom_dl_packer.sv
// Bench for rom_dl_packer: a byte-list packing model feeds an expected-write queue
// that a per-cycle monitor checks against every SDRAM handshake.
module tb_rom_dl_packer;

   typedef struct packed {
      logic [23:0] a;
      logic [15:0] d;
      logic [1:0]  be;
   } word_t;

   typedef struct packed {
      logic [24:0] a;
      logic [7:0]  d;
   } byte_t;

   logic        clk_sys = 1'b0;
   logic        rst_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        ioctl_wait;
   logic        sdram_req;
   logic        sdram_ack = 1'b0;
   logic [23:0] sdram_addr;
   logic [15:0] sdram_din;
   logic [1:0]  sdram_be;
   logic        dl_busy;
   logic        dl_done;

   int    total = 0;
   int    bad = 0;
   int    n_words = 0;
   int    n_done = 0;
   logic  prev_ge = 1'b0;
   word_t exp_q[$];
   byte_t bq[$];
   word_t mq[$];

   always #5 clk_sys = ~clk_sys;

   rom_dl_packer #(.FIFO_AW(3), .WAIT_LVL(6)) dut (
      .clk_sys        (clk_sys),
      .rst_n          (rst_n),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .sdram_req      (sdram_req),
      .sdram_ack      (sdram_ack),
      .sdram_addr     (sdram_addr),
      .sdram_din      (sdram_din),
      .sdram_be       (sdram_be),
      .dl_busy        (dl_busy),
      .dl_done        (dl_done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   function automatic word_t mk(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
      word_t w;
      w.a  = a;
      w.d  = d;
      w.be = be;
      return w;
   endfunction

   function automatic byte_t mb(input logic [24:0] a, input logic [7:0] d);
      byte_t b;
      b.a = a;
      b.d = d;
      return b;
   endfunction

   // Look-ahead pairing: an even byte directly followed by its odd partner makes a
   // full word; any other byte stands alone in its own half of the word.
   task automatic model_pack();
      int    i;
      byte_t b;
      mq.delete();
      i = 0;
      while (i < bq.size()) begin
         b = bq[i];
         if (b.a[0] == 1'b0 && (i + 1) < bq.size() && bq[i + 1].a == b.a + 25'd1) begin
            mq.push_back(mk(b.a[24:1], {b.d, bq[i + 1].d}, 2'b11));
            i = i + 2;
         end else if (b.a[0] == 1'b0) begin
            mq.push_back(mk(b.a[24:1], {b.d, 8'h00}, 2'b10));
            i = i + 1;
         end else begin
            mq.push_back(mk(b.a[24:1], {8'h00, b.d}, 2'b01));
            i = i + 1;
         end
      end
   endtask

   // Monitor: every handshake against the expected queue, registered wait level, overflow.
   always @(negedge clk_sys) begin
      word_t w;
      if (!rst_n) begin
         prev_ge = 1'b0;
      end else begin
         chk("wait_level", ioctl_wait, prev_ge);
         prev_ge = (dut.fifo_count >= 4'd6);
         if (dut.fifo_push && dut.fifo_full) begin
            bad++;
            $display("FAIL overflow: push while full, count=%0d", dut.fifo_count);
         end
         if (sdram_req && sdram_ack) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got addr=0x%0h din=0x%0h be=%b expected none",
                        sdram_addr, sdram_din, sdram_be);
            end else begin
               w = exp_q.pop_front();
               chk("wr_addr", sdram_addr, w.a);
               chk("wr_din", sdram_din, w.d);
               chk("wr_be", sdram_be, w.be);
            end
            n_words++;
         end
         if (dl_done) n_done++;
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int hold);
      int guard;
      guard = 0;
      while (ioctl_wait === 1'b1 && guard < 3000) begin
         tick();
         guard++;
      end
      if (guard >= 3000) begin
         total++;
         bad++;
         $display("FAIL wait_timeout: ioctl_wait stuck at 1 expected release");
      end
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      repeat (hold) tick();
      ioctl_wr = 1'b0;
      repeat (2) tick();
   endtask

   task automatic do_download(input string name, input int hold, input int exp_words);
      int w0, d0, guard;
      model_pack();
      foreach (mq[k]) exp_q.push_back(mq[k]);
      w0 = n_words;
      d0 = n_done;
      ioctl_download = 1'b1;
      repeat (3) tick();
      chk({name, "_busy"}, dl_busy, 1'b1);
      foreach (bq[k]) send_byte(bq[k].a, bq[k].d, hold);
      ioctl_download = 1'b0;
      guard = 0;
      while (n_done == d0 && guard < 500) begin
         tick();
         guard++;
      end
      chk({name, "_done_seen"}, n_done - d0, 1);
      chk({name, "_done_late"}, guard >= 2, 1'b1);
      chk({name, "_words"}, n_words - w0, exp_words);
      chk({name, "_queue_left"}, exp_q.size(), 0);
      repeat (4) tick();
      chk({name, "_done_once"}, n_done - d0, 1);
      chk({name, "_idle"}, dl_busy, 1'b0);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_wait"}, ioctl_wait, 1'b0);
      chk({name, "_req"}, sdram_req, 1'b0);
      chk({name, "_busy"}, dl_busy, 1'b0);
      chk({name, "_done"}, dl_done, 1'b0);
      chk({name, "_be"}, sdram_be, 2'b00);
      chk({name, "_addr"}, sdram_addr, 24'h0);
      chk({name, "_din"}, sdram_din, 16'h0);
   endtask

   initial begin
      int   w_start, saw_req;
      repeat (3) @(posedge clk_sys);
      #1;
      chk_zero("reset");
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Sequential bytes, ack tied high.
      sdram_ack = 1'b1;
      bq.delete();
      for (int i = 0; i < 8; i++) bq.push_back(mb(25'(i), 8'(i)));
      model_pack();
      chk("pin_seq_n", mq.size(), 4);
      chk("pin_seq_w0", mq[0], mk(24'h0, 16'h0001, 2'b11));
      chk("pin_seq_w3", mq[3], mk(24'h3, 16'h0607, 2'b11));
      do_download("seq", 1, 4);

      // Odd byte count: trailing even byte flushed alone.
      bq.delete();
      bq.push_back(mb(25'h100, 8'hAA));
      bq.push_back(mb(25'h101, 8'hBB));
      bq.push_back(mb(25'h102, 8'hCC));
      model_pack();
      chk("pin_odd_w0", mq[0], mk(24'h80, 16'hAABB, 2'b11));
      chk("pin_odd_w1", mq[1], mk(24'h81, 16'hCC00, 2'b10));
      do_download("odd", 1, 2);

      // Non-sequential addresses.
      bq.delete();
      bq.push_back(mb(25'd4, 8'h11));
      bq.push_back(mb(25'd9, 8'h22));
      model_pack();
      chk("pin_nseq_w0", mq[0], mk(24'd2, 16'h1100, 2'b10));
      chk("pin_nseq_w1", mq[1], mk(24'd4, 16'h0022, 2'b01));
      do_download("nseq", 1, 2);

      // Back-pressure: ack held low while 20 bytes stream, then released.
      sdram_ack = 1'b0;
      bq.delete();
      for (int i = 0; i < 20; i++) bq.push_back(mb(25'h1000 + 25'(i), 8'(8'h40 + 8'(i * 7))));
      w_start = n_words;
      fork
         do_download("bp", 2, 10);
         begin
            repeat (150) tick();
            chk("bp_wait_high", ioctl_wait, 1'b1);
            chk("bp_req_high", sdram_req, 1'b1);
            chk("bp_no_write", n_words - w_start, 0);
            sdram_ack = 1'b1;
         end
      join

      // Stretched strobe: each 5-cycle pulse is one byte.
      bq.delete();
      for (int i = 0; i < 6; i++) bq.push_back(mb(25'h200 + 25'(i), 8'(8'h30 + i)));
      do_download("stretch", 5, 3);

      // Reset mid-download with three words queued.
      sdram_ack = 1'b0;
      bq.delete();
      ioctl_download = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 6; i++) send_byte(25'h40 + 25'(i), 8'(8'h90 + i), 1);
      repeat (3) tick();
      chk("pre_rst_req", sdram_req, 1'b1);
      chk("pre_rst_count", dut.fifo_count, 4'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      exp_q.delete();
      ioctl_download = 1'b0;
      sdram_ack = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      saw_req = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (sdram_req) saw_req++;
      end
      chk("post_rst_no_req", saw_req, 0);
      chk("post_rst_busy", dl_busy, 1'b0);

      // Normal operation resumes after the reset.
      bq.delete();
      bq.push_back(mb(25'h300, 8'h5A));
      bq.push_back(mb(25'h301, 8'hA5));
      do_download("after_rst", 1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rom_dl_packer.md
# rom_dl_packer

Byte-to-word packer and write buffer between the SPI download receiver and the SDRAM controller's download write port. It takes the byte stream produced during a ROM download (`ioctl_*`), pairs bytes into 16-bit big-endian words, and queues them in a small FIFO. It then issues one word write per handshake to SDRAM, back-pressuring the receiver through `ioctl_wait`. It also signals the end of download once every byte has reached SDRAM.

## Interface
Parameters:
- `FIFO_AW`, 3: FIFO address width; depth = 2^FIFO_AW words.
- `WAIT_LVL`, 6: FIFO occupancy at or above which `ioctl_wait` is asserted.

Ports:
- `clk_sys` in 1: system clock; the only clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ioctl_download` in 1: download active level from the receiver.
- `ioctl_wr` in 1: byte strobe; may stay high several cycles per byte.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: back-pressure to the receiver.
- `sdram_req` out 1: write request.
- `sdram_ack` in 1: one-cycle accept from the SDRAM controller.
- `sdram_addr` out 24: word address (`ioctl_addr[24:1]`).
- `sdram_din` out 16: write data; even byte in [15:8], odd byte in [7:0].
- `sdram_be` out 2: byte enables; [1] covers [15:8], [0] covers [7:0].
- `dl_busy` out 1: download or drain in progress.
- `dl_done` out 1: one-cycle pulse when the drain completes.

## Operation
- Byte event: the rising edge of `ioctl_wr`, detected against a registered copy. A strobe held high for N cycles counts as one byte. Edges are ignored while `ioctl_download` = 0.
- Pending-byte register holds an address, a data byte and a valid bit.
- Even address with pending empty: store the byte in pending.
- Odd address whose word address equals the pending word address: push {pending, byte} with `be` = 11, then clear pending.
- Mismatch, meaning odd with no matching pending byte, or even while pending is valid:
  - First push the pending byte alone (`be` = 10) if one is held.
  - Then handle the new byte: an odd byte is pushed alone with `be` = 01; an even byte becomes the new pending byte.
  - This case costs two FIFO pushes, so `WAIT_LVL` ≤ depth−2 is required.
- FIFO entry: {word addr 24, data 16, be 2}. Push while full is a design error; the bench asserts it never occurs.
- Output stage:
  - `sdram_req` is asserted while the FIFO is non-empty, with its fields taken from the head entry.
  - On a cycle with `sdram_ack` = 1 and `sdram_req` = 1, the head is popped. Outputs update on the next cycle.
  - `sdram_ack` while `sdram_req` = 0 is ignored.
- FSM states:
  - `IDLE`: go to `RUN` on `ioctl_download` rising.
  - `RUN`: go to `FLUSH` on `ioctl_download` falling.
  - `FLUSH`: push the pending byte (`be` = 10) if valid, then go to `DRAIN`. This takes one cycle.
  - `DRAIN`: when the FIFO is empty and no request is outstanding, pulse `dl_done` and go to `IDLE`.
  - A new `ioctl_download` rising edge seen in `FLUSH` or `DRAIN` is held and acted on after `IDLE`. Bytes are not accepted until the FSM re-enters `RUN`.
- `dl_busy` = 1 in every state except `IDLE`.
- `ioctl_wait` = (occupancy ≥ `WAIT_LVL`), registered.
- Reset, at any time including mid-download:
  - `ioctl_wait`, `sdram_req`, `dl_busy`, `dl_done`, `sdram_be` all 0.
  - `sdram_addr` and `sdram_din` 0.
  - FIFO empty, pending invalid, FSM in `IDLE`.
  - Bytes in flight are discarded.

## Timing
- Byte to FIFO: the edge is detected in cycle 0 and the push happens at the end of cycle 1. The mismatch case takes cycles 1 and 2.
- FIFO to request: `sdram_req` rises one cycle after the first push into an empty FIFO.
- Throughput: one word per cycle when `sdram_ack` is tied high.
- `ioctl_wait` rises within 1 cycle of occupancy reaching `WAIT_LVL`, and falls within 1 cycle of it dropping below.
- `dl_done` comes at least 2 cycles after `ioctl_download` falls.
- Occupancy counter is FIFO_AW+1 bits. Read and write pointers wrap modulo depth.

## Structure
- Package `rom_dl_pkg`:
  - typedef `dl_word_t` {addr[23:0], data[15:0], be[1:0]}.
  - FSM enum `dl_st_e` {IDLE, RUN, FLUSH, DRAIN}.
  - localparam `BE_HI` = 2'b10, `BE_LO` = 2'b01, `BE_ALL` = 2'b11.
- Sub-module `rom_dl_fifo`: synchronous single-clock FIFO parameterised by type/width and FIFO_AW. It provides `push`, `pop`, `full`, `empty` and `count`.

## Test plan
- Sequential bytes 0x00..0x07 at addr 0..7 with ack tied high.
  - Expect 4 writes: addr 0..3, din 0x0001, 0x0203, 0x0405, 0x0607, be 11 each.
  - Then one `dl_done` pulse.
- Odd byte count: 3 bytes 0xAA, 0xBB, 0xCC at addr 0x100..0x102, then download falls.
  - Expect {0x80, 0xAABB, 11} then {0x81, 0xCC00, 10}.
- Non-sequential input: byte 0x11 at addr 4, then byte 0x22 at addr 9.
  - Expect {2, 0x1100, 10} then {4, 0x0022, 01}.
- Back-pressure: ack held 0, stream 20 bytes with a 2-cycle `ioctl_wr`.
  - `ioctl_wait` asserts when occupancy reaches 6; the FIFO never overflows.
  - After ack is released, all 10 words arrive in order.
- Stretched strobe: `ioctl_wr` held 5 cycles per byte.
  - Each byte is counted once; the word count matches the byte count/2.
- Reset mid-download: `rst_n` low with 3 words queued.
  - All outputs go to 0 immediately.
  - After release there is no `sdram_req` until new bytes arrive.
